// File: rtl/exc_ctrl.sv
// MEM-stage exception detection and arbitration: writes the winning exception
// into CP0, flushes the pipeline and hands fetch a redirect PC via valid/ready.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_indelayslot,
  input  logic [31:0] mem_addr,
  input  logic        f_adel,
  input  logic        d_ri,
  input  logic        e_ov,
  input  logic        d_sys,
  input  logic        d_bp,
  input  logic        d_eret,
  input  logic        m_adel,
  input  logic        m_ades,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic        exc_en,
  output logic [4:0]  exc_type,
  output logic [31:0] exc_pc,
  output logic [31:0] exc_badvaddr,
  output logic        exc_indelayslot,
  output logic [5:0]  int_pending,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready
);

  localparam logic [4:0] CODE_INT  = 5'h00;
  localparam logic [4:0] CODE_ADEL = 5'h04;
  localparam logic [4:0] CODE_ADES = 5'h05;
  localparam logic [4:0] CODE_SYS  = 5'h08;
  localparam logic [4:0] CODE_BP   = 5'h09;
  localparam logic [4:0] CODE_RI   = 5'h0a;
  localparam logic [4:0] CODE_OV   = 5'h0c;
  localparam logic [4:0] CODE_ERET = 5'h0e;

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [5:0]  r_sync [SYNC_STAGES];
  logic [31:0] r_target;
  logic        w_irq;
  logic        w_anyFlag;
  logic        w_take;
  logic [4:0]  w_code;
  logic [31:0] w_badvaddr;
  logic        w_isEret;
  logic        w_unused;

  // hw_int is asynchronous; only the last flop of the chain is ever observed.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign int_pending = r_sync[SYNC_STAGES-1];

  assign w_irq = cp0_status[0] & ~cp0_status[1] &
                 (|({int_pending, cp0_cause[9:8]} & cp0_status[15:8]));
  assign w_anyFlag = f_adel | d_ri | e_ov | d_sys | d_bp | d_eret | m_adel | m_ades;
  assign w_take = (r_state == IDLE) & mem_valid & ~mem_stall & (w_irq | w_anyFlag);

  assign w_unused = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10], cp0_cause[7:0]};

  // Priority chain: interrupts beat everything, then fetch-side faults down to MEM faults.
  always_comb begin
    w_code     = CODE_INT;
    w_badvaddr = '0;
    w_isEret   = 1'b0;
    if (w_irq) begin
      w_code = CODE_INT;
    end else if (f_adel) begin
      w_code     = CODE_ADEL;
      w_badvaddr = mem_pc;
    end else if (d_ri) begin
      w_code = CODE_RI;
    end else if (e_ov) begin
      w_code = CODE_OV;
    end else if (d_sys) begin
      w_code = CODE_SYS;
    end else if (d_bp) begin
      w_code = CODE_BP;
    end else if (d_eret) begin
      w_code   = CODE_ERET;
      w_isEret = 1'b1;
    end else if (m_adel) begin
      w_code     = CODE_ADEL;
      w_badvaddr = mem_addr;
    end else if (m_ades) begin
      w_code     = CODE_ADES;
      w_badvaddr = mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:     if (w_take) w_nextState = REDIRECT;
      REDIRECT: if (redirect_ready) w_nextState = IDLE;
      default:  w_nextState = IDLE;
    endcase
  end

  // EPC is captured in the take cycle so later CP0 writes cannot disturb the ERET target.
  always_ff @(posedge clk) begin
    if (rst)         r_target <= '0;
    else if (w_take) r_target <= w_isEret ? cp0_epc : EXC_VECTOR;
  end

  always_comb begin
    exc_en          = 1'b0;
    exc_type        = '0;
    exc_pc          = '0;
    exc_badvaddr    = '0;
    exc_indelayslot = 1'b0;
    flush           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    case (r_state)
      IDLE: begin
        if (w_take) begin
          exc_en          = 1'b1;
          exc_type        = w_code;
          exc_pc          = mem_pc;
          exc_badvaddr    = w_badvaddr;
          exc_indelayslot = mem_indelayslot;
          flush           = 1'b1;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = r_target;
        flush          = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
